// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: bus widths, DMA states, layer-info map.
package cnn_pkg;

   localparam int unsigned MEM_ADDR_SIZE = 20;
   localparam int unsigned DATA_SIZE     = 16;
   localparam int unsigned BLOCK_SIZE    = 150;
   localparam int unsigned CNT_W         = 16;

   // Fixed locations of the layer table read by the layer controller
   localparam logic [MEM_ADDR_SIZE-1:0] LAYER_COUNT_ADDR = 20'h00000;
   localparam logic [MEM_ADDR_SIZE-1:0] LAYER_INFO_ADDR  = 20'h00001;
   localparam logic [CNT_W-1:0]         LAYER_INFO_WORDS = 16'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } dma_state_t;

   // Effective transfer length: 0 and anything above max both mean max
   function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] wc,
                                                    input int unsigned       max);
      if ((wc == '0) || (wc > CNT_W'(max))) return CNT_W'(max);
      return wc;
   endfunction

endpackage

// File: rtl/cnn_block_dma_if.sv
// Controller request/completion handshake plus the single-port RAM read port.
interface cnn_block_dma_if #(
   parameter int unsigned MEM_ADDR_SIZE = cnn_pkg::MEM_ADDR_SIZE,
   parameter int unsigned DATA_SIZE     = cnn_pkg::DATA_SIZE
);
   logic                     dmaEnable;
   logic [MEM_ADDR_SIZE-1:0] address;
   logic [15:0]              wordCount;
   logic                     busy;
   logic                     opDone;
   logic [MEM_ADDR_SIZE-1:0] memAddr;
   logic                     memRead;
   logic [DATA_SIZE-1:0]     memData;

   // Controller and RAM side
   modport master (
      output dmaEnable, address, wordCount, memData,
      input  busy, opDone, memAddr, memRead
   );

   // DMA side
   modport slave (
      input  dmaEnable, address, wordCount, memData,
      output busy, opDone, memAddr, memRead
   );
endinterface

// File: rtl/cnn_block_dma.sv
// Block-read DMA: fetches N consecutive words into a parallel register buffer.
module cnn_block_dma #(
   parameter int unsigned MEM_ADDR_SIZE = cnn_pkg::MEM_ADDR_SIZE,
   parameter int unsigned DATA_SIZE     = cnn_pkg::DATA_SIZE,
   parameter int unsigned BLOCK_SIZE    = cnn_pkg::BLOCK_SIZE
) (
   input  logic                 clk,
   input  logic                 reset,
   cnn_block_dma_if.slave       bus,
   output logic [DATA_SIZE-1:0] dmaOut [0:BLOCK_SIZE-1]
);
   import cnn_pkg::*;

   dma_state_t               state_q, state_d;
   logic [MEM_ADDR_SIZE-1:0] base_q, base_d;
   logic [CNT_W-1:0]         n_q, n_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [MEM_ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
   logic                     mem_read_q, mem_read_d;
   logic                     busy_q, busy_d;
   logic                     op_done_q, op_done_d;
   logic [DATA_SIZE-1:0]     buf_q [0:BLOCK_SIZE-1];
   logic [DATA_SIZE-1:0]     buf_d [0:BLOCK_SIZE-1];
   logic                     clr;
   logic                     wr_en;
   logic [CNT_W-1:0]         wr_idx;

   // Next state, read issue and one-hot buffer write decode.
   // cnt_q counts reads already issued, including the one on the bus now.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      mem_addr_d = mem_addr_q;
      mem_read_d = mem_read_q;
      busy_d     = busy_q;
      op_done_d  = 1'b0;
      clr        = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = '0;

      case (state_q)
         IDLE: begin
            if (bus.dmaEnable) begin
               state_d    = READ;
               base_d     = bus.address;
               n_d        = clamp_count(bus.wordCount, BLOCK_SIZE);
               cnt_d      = CNT_W'(1);
               mem_addr_d = bus.address;
               mem_read_d = 1'b1;
               busy_d     = 1'b1;
               clr        = 1'b1;
            end
         end
         READ: begin
            // Data on memData belongs to the read issued last cycle
            wr_en  = (cnt_q >= CNT_W'(2));
            wr_idx = cnt_q - CNT_W'(2);
            if (cnt_q < n_q) begin
               mem_addr_d = base_q + MEM_ADDR_SIZE'(cnt_q);
               cnt_d      = cnt_q + CNT_W'(1);
            end else begin
               mem_read_d = 1'b0;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            wr_en     = 1'b1;
            wr_idx    = n_q - CNT_W'(1);
            op_done_d = 1'b1;
            state_d   = DONE;
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
         buf_d[j] = buf_q[j];
         if (clr)
            buf_d[j] = '0;
         else if (wr_en && (wr_idx == CNT_W'(j)))
            buf_d[j] = bus.memData;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         base_q     <= '0;
         n_q        <= '0;
         cnt_q      <= '0;
         mem_addr_q <= '0;
         mem_read_q <= 1'b0;
         busy_q     <= 1'b0;
         op_done_q  <= 1'b0;
         for (int unsigned j = 0; j < BLOCK_SIZE; j++) buf_q[j] <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         mem_addr_q <= mem_addr_d;
         mem_read_q <= mem_read_d;
         busy_q     <= busy_d;
         op_done_q  <= op_done_d;
         buf_q      <= buf_d;
      end
   end

   assign bus.memAddr = mem_addr_q;
   assign bus.memRead = mem_read_q;
   assign bus.busy    = busy_q;
   assign bus.opDone  = op_done_q;
   assign dmaOut      = buf_q;

endmodule
